maxpool2x2_stream: RTL and testbench
====================================

# maxpool2x2_stream

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of the convolution layer. It consumes the conv layer's raster-order packed multi-filter output stream and emits one pooled packed word per 2×2 window. It uses a half-width line buffer and no frame buffer. Its output keeps the same valid/frame handshake style, so a further conv or pool stage can chain on it.

## Interface
- DATA_WIDTH, 8, signed width of one channel sample
- NUM_CH, 3, channels per packed word (equals upstream NUM_FILTERS)
- IMG_WIDTH, 8, input feature-map width in samples
- IMG_HEIGHT, 8, input feature-map height in rows
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pixel_in  in  NUM_CH*DATA_WIDTH  packed input; channel c at [(c+1)*DATA_WIDTH-1 -: DATA_WIDTH], two's complement
- pixel_valid  in  1  pixel_in is accepted on this edge
- frame_start  in  1  one-cycle pulse; restarts raster position to (0,0)
- pool_out  out  NUM_CH*DATA_WIDTH  packed pooled result, same channel layout
- pool_valid  out  1  pool_out valid for exactly this cycle
- frame_done  out  1  pulses together with the last pool_valid of a frame

## Operation
- Raster counters x (0..IMG_WIDTH-1) and y (0..IMG_HEIGHT-1) advance on each accepted pixel. x wraps to 0 and y increments at row end.
- After the final pixel, y saturates at a DONE flag. Further pixels are ignored until frame_start.
- frame_start clears x, y and DONE. If pixel_valid is high in the same cycle, that pixel is taken as (0,0).
- All comparisons are signed, per channel, and independent.
- Even x: the pixel is latched into the horizontal register h_reg.
- Odd x: h_max = max(h_reg, pixel_in).
  - Even y: h_max is written to line_buf[x>>1].
  - Odd y: pool_out <= max(line_buf[x>>1], h_max) and pool_valid <= 1.
- Odd IMG_WIDTH: the last column is dropped. Odd IMG_HEIGHT: the last row is dropped. Output size is floor(W/2) × floor(H/2).
- frame_done asserts on the output for the pixel at y = 2*(IMG_HEIGHT/2)-1, x = 2*(IMG_WIDTH/2)-1.
- Gaps in pixel_valid are allowed anywhere. State holds and no output is produced.
- No backpressure: the downstream stage must accept every pool_valid.

## Timing
- Latency: pool_valid is high in the cycle after the edge that accepted the odd-row, odd-column pixel.
- Output rate: at most one output per two input pixels on odd rows.
- Reset values:
  - pool_out = 0, pool_valid = 0, frame_done = 0.
  - x = y = 0, DONE = 0, h_reg = 0.
  - line_buf contents are don't-care.
- Reset mid-frame aborts the frame. The next accepted pixel is (0,0) even without frame_start.
- frame_start mid-frame discards partial state: line_buf is not read before it is rewritten.
- A pool_valid already registered when frame_start arrives still presents for its one cycle.
- Without pixel_valid, pool_valid and frame_done are single-cycle pulses only.

## Configuration
- MAXPOOL_RELU_EN
  - Defined: each incoming channel sample is clamped as max(s, 0) before pooling (fused ReLU). pool_out is then never negative.
  - Undefined: raw signed samples are pooled.
- Ports and latency are identical in both builds.

## Structure
- The shared package cnn_pkg holds:
  - DATA_WIDTH default
  - the channel-slice helper function
  - the signed max function
- pool_line_buffer is one sub-module:
  - depth IMG_WIDTH/2, width NUM_CH*DATA_WIDTH
  - one write port and one read port at the same address, read combinational
  - implemented as registers; no reset on the storage
- Top level holds the counters, h_reg, compare tree and output registers.

## Test plan
- Ramp: channel c of pixel (y,x) = c*64 + y*8 + x, 64 contiguous pixels.
  - 16 outputs; output k=(r,col) has channel c = c*64 + (2r+1)*8 + 2col + 1 (k0 ch0 = 9, k15 ch0 = 63).
  - frame_done coincides with output 16.
- Signed extremes: one window {-128, 127, -1, 0} in ch0.
  - Result 127.
  - A window of all -5 gives -5 (0xFB) without MAXPOOL_RELU_EN and 0 with it.
- Bubbles: the ramp frame with pixel_valid low every other cycle gives identical values and count to the ramp test.
  - Each pool_valid comes exactly 1 cycle after its odd/odd pixel.
- Mid-frame restart: frame_start asserted after 20 pixels, then a full new frame with all pixels = 7.
  - Exactly 16 outputs, all 7.
  - No output mixes old-frame data.
- Overrun and reset:
  - 70 pixels without frame_start gives 16 outputs; pixels 65-70 are ignored.
  - rst held 1 cycle at pixel 30, then 64 new pixels, gives a clean 16-output frame.
  - All outputs are 0 during and immediately after reset.
- Odd size: IMG_WIDTH=5, IMG_HEIGHT=5 gives 4 outputs (2×2).
  - Column 4 and row 4 never influence results.
  - frame_done occurs on the pixel (3,3) output.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath helpers: default sample width, packed-channel slicing
// and signed maximum used by the pooling compare tree.
package cnn_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int BUS_MAX        = 256;

    // Sign-extended channel c of a zero-padded packed bus with dw-bit lanes.
    function automatic logic signed [31:0] ch_slice(
        input logic [BUS_MAX-1:0] bus,
        input int                 c,
        input int                 dw
    );
        logic [31:0] lo;
        lo = 32'(bus >> (c * dw));
        return $signed(lo << (32 - dw)) >>> (32 - dw);
    endfunction

    function automatic logic signed [31:0] smax(
        input logic signed [31:0] a,
        input logic signed [31:0] b
    );
        logic signed [31:0] r;
        if (a > b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-width row store for the 2x2 pooler: one write and one combinational
// read port sharing a single address; storage is deliberately not reset.
module pool_line_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24,
    parameter int AW    = 2
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Row-pair storage write
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster packed-channel stream.
// Optional fused ReLU on the input samples when MAXPOOL_RELU_EN is defined.
module maxpool2x2_stream
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_CH     = 3,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] pixel_in,
    input  logic                         pixel_valid,
    input  logic                         frame_start,
    output logic [NUM_CH*DATA_WIDTH-1:0] pool_out,
    output logic                         pool_valid,
    output logic                         frame_done
);

    localparam int BUS_W    = NUM_CH * DATA_WIDTH;
    localparam int XW       = $clog2(IMG_WIDTH + 1);
    localparam int YW       = $clog2(IMG_HEIGHT + 1);
    localparam int LB_DEPTH = (IMG_WIDTH / 2 > 0) ? IMG_WIDTH / 2 : 1;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_PLAST = XW'(2 * (IMG_WIDTH / 2) - 1);
    localparam logic [YW-1:0] Y_PLAST = YW'(2 * (IMG_HEIGHT / 2) - 1);

    logic [XW-1:0]    x_q, x_d, cur_x_s;
    logic [YW-1:0]    y_q, y_d, cur_y_s;
    logic             done_q, done_d;
    logic [BUS_W-1:0] h_reg_q, h_reg_d;
    logic [BUS_W-1:0] pool_out_q, pool_out_d;
    logic             pool_valid_q, pool_valid_d;
    logic             frame_done_q, frame_done_d;

    logic             accept_s;
    logic             lb_we_s;
    logic [AW-1:0]    lb_addr_s;
    logic [BUS_W-1:0] lb_rd_s;
    logic [BUS_W-1:0] pix_s, h_max_s, p_max_s;
    logic [BUS_MAX-1:0] pix_ext_s, h_ext_s, lb_ext_s;

    // Effective raster position: frame_start forces the current pixel to (0,0)
    always_comb begin
        accept_s = pixel_valid && (frame_start || !done_q);
        if (frame_start) begin
            cur_x_s = '0;
            cur_y_s = '0;
        end else begin
            cur_x_s = x_q;
            cur_y_s = y_q;
        end
    end

    assign lb_we_s   = accept_s && cur_x_s[0] && !cur_y_s[0];
    assign lb_addr_s = AW'(cur_x_s >> 1);

    pool_line_buffer #(
        .DEPTH (LB_DEPTH),
        .WIDTH (BUS_W),
        .AW    (AW)
    ) u_line_buf (
        .clk_i     (clk),
        .wr_en_i   (lb_we_s),
        .addr_i    (lb_addr_s),
        .wr_data_i (h_max_s),
        .rd_data_o (lb_rd_s)
    );

    // Zero-pad packed buses to the helper width
    always_comb begin
        pix_ext_s = '0;
        h_ext_s   = '0;
        lb_ext_s  = '0;
        pix_ext_s[BUS_W-1:0] = pixel_in;
        h_ext_s[BUS_W-1:0]   = h_reg_q;
        lb_ext_s[BUS_W-1:0]  = lb_rd_s;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [DATA_WIDTH-1:0] s_raw, s_in, hm, pm;
        assign s_raw = DATA_WIDTH'(ch_slice(pix_ext_s, c, DATA_WIDTH));
`ifdef MAXPOOL_RELU_EN
        assign s_in  = DATA_WIDTH'(smax(32'(s_raw), 32'sd0));
`else
        assign s_in  = s_raw;
`endif
        assign hm = DATA_WIDTH'(smax(ch_slice(h_ext_s, c, DATA_WIDTH), 32'(s_in)));
        assign pm = DATA_WIDTH'(smax(ch_slice(lb_ext_s, c, DATA_WIDTH), 32'(hm)));
        assign pix_s[c*DATA_WIDTH +: DATA_WIDTH]   = s_in;
        assign h_max_s[c*DATA_WIDTH +: DATA_WIDTH] = hm;
        assign p_max_s[c*DATA_WIDTH +: DATA_WIDTH] = pm;
    end

    // Next-state: raster advance, horizontal latch and pooled result
    always_comb begin
        x_d          = cur_x_s;
        y_d          = cur_y_s;
        done_d       = frame_start ? 1'b0 : done_q;
        h_reg_d      = h_reg_q;
        pool_out_d   = pool_out_q;
        pool_valid_d = 1'b0;
        frame_done_d = 1'b0;
        if (accept_s) begin
            if (cur_x_s == X_LAST) begin
                x_d = '0;
                if (cur_y_s == Y_LAST) begin
                    y_d    = '0;
                    done_d = 1'b1;
                end else begin
                    y_d = cur_y_s + YW'(1);
                end
            end else begin
                x_d = cur_x_s + XW'(1);
            end
            if (!cur_x_s[0]) begin
                h_reg_d = pix_s;
            end else if (cur_y_s[0]) begin
                pool_out_d   = p_max_s;
                pool_valid_d = 1'b1;
                frame_done_d = (cur_x_s == X_PLAST) && (cur_y_s == Y_PLAST);
            end else begin
                h_reg_d = h_reg_q;
            end
        end else begin
            h_reg_d = h_reg_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            done_q       <= 1'b0;
            h_reg_q      <= '0;
            pool_out_q   <= '0;
            pool_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            done_q       <= done_d;
            h_reg_q      <= h_reg_d;
            pool_out_q   <= pool_out_d;
            pool_valid_q <= pool_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pool_out   = pool_out_q;
    assign pool_valid = pool_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream: an 8x8 instance and a 5x5 instance,
// directed frames with hand-derived pooled values.
module tb_maxpool2x2_stream;

    localparam int BW = 24;

    typedef struct packed {
        logic [BW-1:0] d;
        logic          fd;
        logic [31:0]   cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [BW-1:0] a_pix, b_pix, a_out, b_out;
    logic          a_val, b_val, a_fs, b_fs;
    logic          a_pv, b_pv, a_fd, b_fd;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        me;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] cyc = 32'd0;
    int          bx[2];
    int          by[2];
    bit          bdone[2];
    bit          chk_zero = 1'b0;
    bit          chk_end  = 1'b0;

    maxpool2x2_stream #(.DATA_WIDTH(8), .NUM_CH(3), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut_a (
        .clk(clk), .rst(rst), .pixel_in(a_pix), .pixel_valid(a_val), .frame_start(a_fs),
        .pool_out(a_out), .pool_valid(a_pv), .frame_done(a_fd)
    );

    maxpool2x2_stream #(.DATA_WIDTH(8), .NUM_CH(3), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut_b (
        .clk(clk), .rst(rst), .pixel_in(b_pix), .pixel_valid(b_val), .frame_start(b_fs),
        .pool_out(b_out), .pool_valid(b_pv), .frame_done(b_fd)
    );

    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic logic [7:0] relu8(input logic [7:0] v);
`ifdef MAXPOOL_RELU_EN
        return v[7] ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    // mode 0 ramp8, 1 signed extremes, 2 constant 7, 3 ramp5 with dropped edge = 120
    function automatic logic [BW-1:0] pix_val(input int mode, input int y, input int x);
        logic [7:0] ch[3];
        logic [7:0] ext_tab[4];
        ext_tab = '{8'h80, 8'h7F, 8'hFF, 8'h00};
        for (int c = 0; c < 3; c++) begin
            case (mode)
                0: ch[c] = 8'(c * 64 + y * 8 + x);
                1: begin
                    if (y < 2 && x < 2) ch[c] = (c == 0) ? ext_tab[y * 2 + x] : 8'h00;
                    else if (y < 2 && x < 4) ch[c] = 8'hFB;
                    else ch[c] = 8'h00;
                end
                2: ch[c] = 8'd7;
                default: ch[c] = (x < 4 && y < 4) ? 8'(c * 30 + y * 5 + x) : 8'd120;
            endcase
        end
        return {ch[2], ch[1], ch[0]};
    endfunction

    // Expected pooled word produced on the odd/odd pixel (y,x)
    function automatic logic [BW-1:0] exp_val(input int mode, input int y, input int x);
        logic [7:0] ch[3];
        for (int c = 0; c < 3; c++) begin
            case (mode)
                0: ch[c] = 8'(c * 64 + y * 8 + x);
                1: begin
                    if (y == 1 && x == 1) ch[c] = (c == 0) ? 8'h7F : 8'h00;
                    else if (y == 1 && x == 3) ch[c] = 8'hFB;
                    else ch[c] = 8'h00;
                end
                2: ch[c] = 8'd7;
                default: ch[c] = 8'(c * 30 + y * 5 + x);
            endcase
            ch[c] = relu8(ch[c]);
        end
        return {ch[2], ch[1], ch[0]};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents an output
    always @(negedge clk) begin
        if (a_pv) begin
            if (qa.size() == 0) begin
                cmp("a_unexpected_output", {8'h00, a_out}, 32'hFFFF_FFFF);
            end else begin
                me = qa.pop_front();
                cmp("a_pool_out", {8'h00, a_out}, {8'h00, me.d});
                cmp("a_frame_done", {31'd0, a_fd}, {31'd0, me.fd});
                cmp("a_latency", cyc, me.cyc);
            end
        end
        if (b_pv) begin
            if (qb.size() == 0) begin
                cmp("b_unexpected_output", {8'h00, b_out}, 32'hFFFF_FFFF);
            end else begin
                me = qb.pop_front();
                cmp("b_pool_out", {8'h00, b_out}, {8'h00, me.d});
                cmp("b_frame_done", {31'd0, b_fd}, {31'd0, me.fd});
                cmp("b_latency", cyc, me.cyc);
            end
        end
        if (a_fd && !a_pv) cmp("a_frame_done_alone", 32'd1, 32'd0);
        if (b_fd && !b_pv) cmp("b_frame_done_alone", 32'd1, 32'd0);
        if (chk_zero) begin
            cmp("zero_a_pool_out", {8'h00, a_out}, 32'd0);
            cmp("zero_a_pool_valid", {31'd0, a_pv}, 32'd0);
            cmp("zero_a_frame_done", {31'd0, a_fd}, 32'd0);
            cmp("zero_b_pool_out", {8'h00, b_out}, 32'd0);
            cmp("zero_b_pool_valid", {31'd0, b_pv}, 32'd0);
        end
        if (chk_end) begin
            cmp("a_missing_outputs", qa.size(), 32'd0);
            cmp("b_missing_outputs", qb.size(), 32'd0);
        end
    end

    task automatic drive(input int sel, input logic [BW-1:0] d, input logic v, input logic fs);
        if (sel == 0) begin
            a_pix = d; a_val = v; a_fs = fs;
        end else begin
            b_pix = d; b_val = v; b_fs = fs;
        end
        @(posedge clk);
        #1;
        a_val = 1'b0; a_fs = 1'b0; b_val = 1'b0; b_fs = 1'b0;
    endtask

    task automatic send_frame(input int sel, input int mode, input int npix, input bit gaps, input bit fs_first);
        int   w;
        int   h;
        bit   fs;
        exp_t e;
        w = (sel == 0) ? 8 : 5;
        h = (sel == 0) ? 8 : 5;
        for (int i = 0; i < npix; i++) begin
            fs = fs_first && (i == 0);
            if (fs) begin
                bx[sel] = 0; by[sel] = 0; bdone[sel] = 1'b0;
            end
            drive(sel, pix_val(mode, by[sel], bx[sel]), 1'b1, fs);
            if (!bdone[sel]) begin
                if ((bx[sel] % 2 == 1) && (by[sel] % 2 == 1) &&
                    (bx[sel] < 2 * (w / 2)) && (by[sel] < 2 * (h / 2))) begin
                    e.d   = exp_val(mode, by[sel], bx[sel]);
                    e.fd  = (bx[sel] == 2 * (w / 2) - 1) && (by[sel] == 2 * (h / 2) - 1);
                    e.cyc = cyc;
                    if (sel == 0) qa.push_back(e);
                    else qb.push_back(e);
                end
                if (bx[sel] == w - 1) begin
                    bx[sel] = 0;
                    if (by[sel] == h - 1) begin
                        by[sel] = 0;
                        bdone[sel] = 1'b1;
                    end else begin
                        by[sel]++;
                    end
                end else begin
                    bx[sel]++;
                end
            end
            if (gaps) drive(sel, '0, 1'b0, 1'b0);
        end
    endtask

    task automatic zero_check();
        chk_zero = 1'b1;
        @(negedge clk);
        #1;
        chk_zero = 1'b0;
    endtask

    task automatic clear_pos();
        for (int s = 0; s < 2; s++) begin
            bx[s] = 0; by[s] = 0; bdone[s] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        a_pix = '0; b_pix = '0;
        a_val = 1'b0; b_val = 1'b0; a_fs = 1'b0; b_fs = 1'b0;
        clear_pos();
        repeat (2) @(posedge clk);
        #1;
        zero_check();
        rst = 1'b0;

        send_frame(0, 0, 64, 1'b0, 1'b1);          // ramp
        repeat (3) drive(0, '0, 1'b0, 1'b0);
        send_frame(0, 1, 64, 1'b0, 1'b1);          // signed extremes
        send_frame(0, 0, 64, 1'b1, 1'b1);          // ramp with bubbles
        send_frame(0, 0, 20, 1'b0, 1'b1);          // partial frame
        send_frame(0, 2, 64, 1'b0, 1'b1);          // restart, all 7
        send_frame(0, 0, 70, 1'b0, 1'b1);          // overrun
        send_frame(0, 0, 30, 1'b0, 1'b1);          // aborted by reset
        rst = 1'b1;
        drive(0, '0, 1'b0, 1'b0);
        clear_pos();
        zero_check();
        rst = 1'b0;
        drive(0, '0, 1'b0, 1'b0);
        zero_check();
        send_frame(0, 0, 64, 1'b0, 1'b0);          // clean frame without frame_start
        send_frame(1, 3, 25, 1'b0, 1'b1);          // 5x5 odd size

        repeat (4) drive(0, '0, 1'b0, 1'b0);
        chk_end = 1'b1;
        @(negedge clk);
        #1;
        chk_end = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
